// File: rtl/sram_port_arb.sv
// Two-master arbiter for the shared single-port SRAM: grants the i or d bus one access
// per cycle and returns one-cycle-latency read data to the master whose read was accepted.
module sram_port_arb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 13,
   parameter bit          RR     = 1'b1
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                arst_i,
   input  logic                i_avalid_i,
   input  logic [ADDR_W-1:0]   i_addr_i,
   input  logic [DATA_W-1:0]   i_wdata_i,
   input  logic [DATA_W/8-1:0] i_wstrb_i,
   output logic                i_ready_o,
   output logic                i_rvalid_o,
   output logic [DATA_W-1:0]   i_rdata_o,
   input  logic                d_avalid_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   input  logic [DATA_W/8-1:0] d_wstrb_i,
   output logic                d_ready_o,
   output logic                d_rvalid_o,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                mem_en_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_wstrb_o,
   input  logic [DATA_W-1:0]   mem_rdata_i
);

   typedef enum logic {MST_I = 1'b0, MST_D = 1'b1} mst_t;

   mst_t last;
   mst_t rd_own;
   logic rd_pend;
   logic gnt_i;
   logic gnt_d;
   logic rd_accept;

   // Grant is suppressed while reset is held so nothing reaches the SRAM during reset.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (cke_i && !arst_i) begin
         if (i_avalid_i && d_avalid_i) begin
            if (RR && (last == MST_D)) gnt_i = 1'b1;
            else                       gnt_d = 1'b1;
         end else begin
            gnt_i = i_avalid_i;
            gnt_d = d_avalid_i;
         end
      end
   end

   always_comb begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wstrb_o = '0;
      if (gnt_d) begin
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_wdata_i;
         mem_wstrb_o = d_wstrb_i;
      end else if (gnt_i) begin
         mem_addr_o  = i_addr_i;
         mem_wdata_o = i_wdata_i;
         mem_wstrb_o = i_wstrb_i;
      end
   end

   assign mem_en_o  = gnt_i | gnt_d;
   assign i_ready_o = gnt_i;
   assign d_ready_o = gnt_d;
   assign rd_accept = mem_en_o && (mem_wstrb_o == '0);

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         rd_pend <= 1'b0;
         rd_own  <= MST_I;
         last    <= MST_D;
      end else if (cke_i) begin
         rd_pend <= rd_accept;
         if (rd_accept) rd_own <= gnt_d ? MST_D : MST_I;
         if (mem_en_o)  last   <= gnt_d ? MST_D : MST_I;
      end
   end

   // The SRAM holds its output while disabled, so a stalled rvalid keeps its data too.
   assign i_rvalid_o = rd_pend && (rd_own == MST_I);
   assign d_rvalid_o = rd_pend && (rd_own == MST_D);
   assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;
   assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed self-checking bench: one round-robin and one fixed-priority arbiter,
// each driving its own behavioural SRAM, fed identical master stimulus.
module tb_sram_port_arb;

   localparam logic [31:0] W10 = 32'hA5A5_0010;
   localparam logic [31:0] W20 = 32'h5A5A_0020;
   localparam logic [31:0] W05 = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        cke;
   logic        arst;
   logic        i_avalid, d_avalid;
   logic [12:0] i_addr, d_addr;
   logic [31:0] i_wdata, d_wdata;
   logic [3:0]  i_wstrb, d_wstrb;

   logic        i_ready [2];
   logic        i_rvalid[2];
   logic [31:0] i_rdata [2];
   logic        d_ready [2];
   logic        d_rvalid[2];
   logic [31:0] d_rdata [2];
   logic        mem_en   [2];
   logic [12:0] mem_addr [2];
   logic [31:0] mem_wdata[2];
   logic [3:0]  mem_wstrb[2];
   logic [31:0] mem_rdata[2];
   logic [31:0] ram [2][8192];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_port_arb #(.DATA_W(32), .ADDR_W(13), .RR(1'b0)) dut_fp (
      .clk_i(clk), .cke_i(cke), .arst_i(arst),
      .i_avalid_i(i_avalid), .i_addr_i(i_addr), .i_wdata_i(i_wdata), .i_wstrb_i(i_wstrb),
      .i_ready_o(i_ready[0]), .i_rvalid_o(i_rvalid[0]), .i_rdata_o(i_rdata[0]),
      .d_avalid_i(d_avalid), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
      .d_ready_o(d_ready[0]), .d_rvalid_o(d_rvalid[0]), .d_rdata_o(d_rdata[0]),
      .mem_en_o(mem_en[0]), .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
      .mem_wstrb_o(mem_wstrb[0]), .mem_rdata_i(mem_rdata[0])
   );

   sram_port_arb #(.DATA_W(32), .ADDR_W(13), .RR(1'b1)) dut_rr (
      .clk_i(clk), .cke_i(cke), .arst_i(arst),
      .i_avalid_i(i_avalid), .i_addr_i(i_addr), .i_wdata_i(i_wdata), .i_wstrb_i(i_wstrb),
      .i_ready_o(i_ready[1]), .i_rvalid_o(i_rvalid[1]), .i_rdata_o(i_rdata[1]),
      .d_avalid_i(d_avalid), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
      .d_ready_o(d_ready[1]), .d_rvalid_o(d_rvalid[1]), .d_rdata_o(d_rdata[1]),
      .mem_en_o(mem_en[1]), .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
      .mem_wstrb_o(mem_wstrb[1]), .mem_rdata_i(mem_rdata[1])
   );

   // Behavioural single-port SRAM per instance; output holds while disabled.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (arst) begin
            ram[k][16] = W10;
            ram[k][32] = W20;
            ram[k][5]  = W05;
            mem_rdata[k] <= '0;
         end else if (mem_en[k]) begin
            if (mem_wstrb[k] != 4'b0000) begin
               for (int b = 0; b < 4; b++)
                  if (mem_wstrb[k][b]) ram[k][mem_addr[k]][8*b +: 8] = mem_wdata[k][8*b +: 8];
            end else begin
               mem_rdata[k] <= ram[k][mem_addr[k]];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(negedge clk);
   endtask

   initial begin
      cke = 1'b1; arst = 1'b1;
      i_avalid = 1'b1; d_avalid = 1'b1;
      i_addr = 13'h10; d_addr = 13'h20;
      i_wdata = '0; d_wdata = '0; i_wstrb = '0; d_wstrb = '0;

      cyc; cyc; #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_i_ready",  i_ready[k],   0);
         chk("rst_d_ready",  d_ready[k],   0);
         chk("rst_mem_en",   mem_en[k],    0);
         chk("rst_mem_addr", mem_addr[k],  0);
         chk("rst_mem_wd",   mem_wdata[k], 0);
         chk("rst_mem_ws",   mem_wstrb[k], 0);
         chk("rst_i_rvalid", i_rvalid[k],  0);
         chk("rst_d_rvalid", d_rvalid[k],  0);
         chk("rst_i_rdata",  i_rdata[k],   0);
         chk("rst_d_rdata",  d_rdata[k],   0);
      end

      // Both masters read continuously: RR alternates starting with i, FP always d.
      arst = 1'b0; #1;
      for (int c = 0; c < 6; c++) begin
         chk("rr_i_ready",  i_ready[1],  (c % 2) == 0);
         chk("rr_d_ready",  d_ready[1],  (c % 2) == 1);
         chk("rr_mem_addr", mem_addr[1], ((c % 2) == 0) ? 32'h10 : 32'h20);
         chk("rr_i_rvalid", i_rvalid[1], (c % 2) == 1);
         chk("rr_d_rvalid", d_rvalid[1], (c > 0) && ((c % 2) == 0));
         chk("rr_i_rdata",  i_rdata[1],  ((c % 2) == 1) ? W10 : 32'h0);
         chk("rr_d_rdata",  d_rdata[1],  ((c > 0) && ((c % 2) == 0)) ? W20 : 32'h0);
         chk("fp_d_ready",  d_ready[0],  1);
         chk("fp_i_ready",  i_ready[0],  0);
         chk("fp_d_rvalid", d_rvalid[0], c > 0);
         chk("fp_d_rdata",  d_rdata[0],  (c > 0) ? W20 : 32'h0);
         chk("fp_i_rvalid", i_rvalid[0], 0);
         cyc; #1;
      end

      d_avalid = 1'b0; #1;
      chk("fp_i_after_d",   i_ready[0],  1);
      chk("rr_i_after_d",   i_ready[1],  1);
      chk("rr_d_rvalid_l",  d_rvalid[1], 1);
      chk("rr_d_rdata_l",   d_rdata[1],  W20);
      chk("fp_d_rvalid_l",  d_rvalid[0], 1);

      cyc; i_avalid = 1'b0; #1;
      chk("fp_i_rvalid_l",  i_rvalid[0], 1);
      chk("fp_i_rdata_l",   i_rdata[0],  W10);
      chk("rr_i_rvalid_l",  i_rvalid[1], 1);
      chk("idle_mem_en",    mem_en[1],   0);

      // Partial write to word 5, then read it back.
      cyc; d_avalid = 1'b1; d_addr = 13'd5; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; #1;
      chk("wr_mem_wstrb",   mem_wstrb[1], 32'h3);
      chk("wr_mem_wdata",   mem_wdata[1], 32'hDEAD_BEEF);
      chk("wr_mem_addr",    mem_addr[1],  32'h5);
      chk("wr_mem_en",      mem_en[1],    1);
      chk("wr_d_ready",     d_ready[1],   1);
      chk("wr_i_rvalid",    i_rvalid[1],  0);

      cyc; d_wstrb = 4'b0000; d_wdata = '0; #1;
      chk("wr_no_rvalid",   d_rvalid[1],  0);
      chk("rd5_mem_wstrb",  mem_wstrb[1], 0);
      chk("rd5_d_ready",    d_ready[1],   1);

      cyc; d_avalid = 1'b0; #1;
      chk("rd5_rvalid",     d_rvalid[1],  1);
      chk("rd5_rdata_rr",   d_rdata[1],   32'h1234_BEEF);
      chk("rd5_rdata_fp",   d_rdata[0],   32'h1234_BEEF);

      // Read accepted, then clock enable dropped for three cycles.
      cyc; i_avalid = 1'b1; i_addr = 13'h10; #1;
      chk("cke_i_ready",    i_ready[1],   1);
      chk("cke_d_rvalid",   d_rvalid[1],  0);

      cyc; cke = 1'b0; d_avalid = 1'b1; d_addr = 13'h20;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk("ckel_i_ready",  i_ready[1],  0);
         chk("ckel_d_ready",  d_ready[1],  0);
         chk("ckel_mem_en",   mem_en[1],   0);
         chk("ckel_i_rvalid", i_rvalid[1], 1);
         chk("ckel_i_rdata",  i_rdata[1],  W10);
         cyc;
      end
      cke = 1'b1; #1;
      chk("ckeh_i_rvalid",  i_rvalid[1],  1);
      chk("ckeh_d_ready",   d_ready[1],   1);
      chk("ckeh_i_ready",   i_ready[1],   0);
      chk("ckeh_mem_addr",  mem_addr[1],  32'h20);

      cyc; i_avalid = 1'b0; d_avalid = 1'b0; #1;
      chk("ckeh_d_rvalid",  d_rvalid[1],  1);
      chk("ckeh_d_rdata",   d_rdata[1],   W20);
      chk("ckeh_i_rvalid2", i_rvalid[1],  0);
      chk("ckeh_i_rdata2",  i_rdata[1],   0);

      // Reset pulsed the cycle after an accepted i read.
      cyc; i_avalid = 1'b1; i_addr = 13'h10; #1;
      chk("ar_i_ready",     i_ready[1],   1);
      cyc; i_avalid = 1'b0; arst = 1'b1; #1;
      chk("ar_rvalid_in",   i_rvalid[1],  0);
      chk("ar_rdata_in",    i_rdata[1],   0);
      #2 arst = 1'b0; #1;
      chk("ar_rvalid_out",  i_rvalid[1],  0);
      cyc; #1;
      chk("ar_rvalid_late", i_rvalid[1],  0);
      cyc; i_avalid = 1'b1; d_avalid = 1'b1; i_addr = 13'h10; d_addr = 13'h20; #1;
      chk("ar_last_i",      i_ready[1],   1);
      chk("ar_last_d",      d_ready[1],   0);
      cyc; i_avalid = 1'b0; d_avalid = 1'b0; #1;
      chk("ar_post_rvalid", i_rvalid[1],  1);
      chk("ar_post_rdata",  i_rdata[1],   W10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sram_port_arb.md
# sram_port_arb

Two-master arbiter and sequencer for the single-port internal SRAM. It grants the instruction bus (i) and data bus (d) access to one shared memory port, one access per cycle. It routes the one-cycle-latency read data back to the master whose read was accepted. It sits between the internal-memory bus logic and a single-port `sram` instance and replaces the dual-port macro in area-constrained builds.

## Interface
- DATA_W, 32, data width in bits; a multiple of 8.
- ADDR_W, 13, word address width.
- RR, 1, arbitration mode: 1 selects round-robin; 0 selects fixed priority, where the data bus wins.

- clk_i  input  1  system clock; one clock domain.
- cke_i  input  1  clock enable; when low, all registers hold and no grant is issued.
- arst_i  input  1  reset, asynchronous and active-high.
- i_avalid_i  input  1  instruction request valid.
- i_addr_i  input  ADDR_W  instruction word address.
- i_wdata_i  input  DATA_W  instruction write data.
- i_wstrb_i  input  DATA_W/8  instruction byte strobes; all zero means a read.
- i_ready_o  output  1  instruction request accepted this cycle.
- i_rvalid_o  output  1  instruction read data valid.
- i_rdata_o  output  DATA_W  instruction read data.
- d_avalid_i, d_addr_i, d_wdata_i, d_wstrb_i, d_ready_o, d_rvalid_o, d_rdata_o: same widths and meanings as the i_* ports, for the data bus.
- mem_en_o  output  1  SRAM enable.
- mem_addr_o  output  ADDR_W  SRAM word address.
- mem_wdata_o  output  DATA_W  SRAM write data.
- mem_wstrb_o  output  DATA_W/8  SRAM byte write enables.
- mem_rdata_i  input  DATA_W  SRAM read data, valid one cycle after an enabled read.

## Operation
- The grant is combinational from the avalid inputs, cke_i and the state.
- gnt_i and gnt_d are one-hot or zero; both are zero when cke_i is low.
- When exactly one master requests, that master is granted.
- When both masters request:
  - RR=0: the d master is granted.
  - RR=1: the master not recorded in `last` is granted.
- `last` register:
  - Updated to the granted master on every grant while cke_i is high.
  - Reset value: d, so the i master wins the first conflict.
- A master that is not granted sees ready_o=0. It must keep avalid_i, addr, wdata and wstrb stable until ready_o=1.
- ready_o equals the master's grant.
- Memory port outputs:
  - mem_en_o = gnt_i | gnt_d.
  - mem_addr_o, mem_wdata_o and mem_wstrb_o are muxed from the granted master.
  - All memory port outputs are 0 when there is no grant.
- An accepted read (grant with wstrb==0) sets `rd_pend` and `rd_own` (i or d) at the next enabled edge.
- The following cycle asserts rvalid_o for the owner for exactly one cycle, with rdata_o = mem_rdata_i.
- An accepted write produces no rvalid.
- rdata_o of the non-owner, and of both masters when rvalid is low, is 0.
- Back-to-back accesses are allowed. A new request may be granted in the same cycle that the previous read's rvalid is returned, giving 1 access per cycle.
- If cke_i is low while rd_pend is set, rvalid_o and rdata_o hold their values, and no new grant is issued.
- Reset:
  - rd_pend=0, rd_own=i, last=d.
  - All ready, rvalid, rdata and mem_* outputs are 0 while reset is asserted, given avalid low or cke low.
  - Asserting reset mid-transaction discards any pending rvalid.

## Timing
- Request to ready: 0 cycles, combinational, when uncontested.
- Read latency: rvalid 1 cycle after the accepting (ready) cycle.
- Worst-case wait with RR=1 and a persistent competitor: 1 cycle.
- With RR=0, the i master can starve indefinitely. This is intended, for boot-copy bursts.
- Combinational paths:
  - avalid_i → ready_o.
  - avalid_i → mem_* outputs.
  - mem_rdata_i → rdata_o.
- No combinational path exists from any input to rvalid_o.

## Test plan
- Reset with both avalids high and cke_i=1, then release → all outputs are 0 during reset. On the first cycle after release, i is granted (last=d), mem_addr_o=i_addr_i, and i_rvalid_o=1 one cycle later.
- RR=1, both masters issue continuous reads (i addr 0x10, d addr 0x20) for 6 cycles → grants alternate i,d,i,d,i,d. Each rvalid arrives 1 cycle after its ready, with rdata = preloaded word.
- RR=0, same stimulus → d is granted every cycle and i_ready_o stays 0. When d drops avalid, i is granted on that cycle.
- Data write 0xDEADBEEF with wstrb=4'b0011 to addr 5, then read addr 5 → mem_wstrb_o=0011 on the write with no rvalid; the read returns 0x????BEEF (upper bytes unchanged).
- Read accepted, then cke_i=0 for 3 cycles → no new ready, mem_en_o=0, and rvalid/rdata hold; normal operation resumes when cke_i=1.
- arst_i pulsed in the cycle after a read accept → the rvalid is never seen, and `last` returns to d.
